// File: rtl/kgp_risc_pkg.sv
// Shared KGP RISC definitions: next-PC selector encodings, branch conditions,
// fetch FSM states and instruction field positions.
package kgp_risc_pkg;

  localparam logic [1:0] CS_SEQ    = 2'b00;
  localparam logic [1:0] CS_BRANCH = 2'b01;
  localparam logic [1:0] CS_JUMP   = 2'b10;
  localparam logic [1:0] CS_JREG   = 2'b11;

  localparam logic [2:0] BT_ALWAYS = 3'b000;
  localparam logic [2:0] BT_ZERO   = 3'b001;
  localparam logic [2:0] BT_NZERO  = 3'b010;
  localparam logic [2:0] BT_CARRY  = 3'b011;
  localparam logic [2:0] BT_NCARRY = 3'b100;
  localparam logic [2:0] BT_SIGN   = 3'b101;
  localparam logic [2:0] BT_OVF    = 3'b110;
  localparam logic [2:0] BT_NOVF   = 3'b111;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH    = 2'd0;
  localparam fetch_state_t ST_WAIT_MEM = 2'd1;
  localparam fetch_state_t ST_ISSUE    = 2'd2;

  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 26;
  localparam int unsigned RS_MSB      = 25;
  localparam int unsigned RS_LSB      = 21;
  localparam int unsigned RT_MSB      = 20;
  localparam int unsigned RT_LSB      = 16;
  localparam int unsigned IMM_MSB     = 15;
  localparam int unsigned IMM_LSB     = 0;
  localparam int unsigned FUNCT_MSB   = 5;
  localparam int unsigned FUNCT_LSB   = 0;
  localparam int unsigned JTARGET_MSB = 25;
  localparam int unsigned JTARGET_LSB = 0;

  function automatic logic branch_taken(input logic [2:0] branch_type,
                                        input logic       zero,
                                        input logic       carry,
                                        input logic       sign,
                                        input logic       overflow);
    logic taken;
    case (branch_type)
      BT_ALWAYS: taken = 1'b1;
      BT_ZERO:   taken = zero;
      BT_NZERO:  taken = ~zero;
      BT_CARRY:  taken = carry;
      BT_NCARRY: taken = ~carry;
      BT_SIGN:   taken = sign;
      BT_OVF:    taken = overflow;
      BT_NOVF:   taken = ~overflow;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC resolution from the control_unit selectors and ALU flags.
module next_pc_logic
  import kgp_risc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] jump_target,
  input  logic [1:0]  counter_selector,
  input  logic [2:0]  branch_type,
  input  logic        flag_zero,
  input  logic        flag_carry,
  input  logic        flag_sign,
  input  logic        flag_overflow,
  input  logic [29:0] reg_target_hi,
  output logic        taken,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] branch_offset;

  always_comb begin
    pc4           = pc + 32'd4;
    branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
    taken         = branch_taken(branch_type, flag_zero, flag_carry, flag_sign, flag_overflow);
    next_pc       = pc4;
    unique case (counter_selector)
      CS_SEQ:    next_pc = pc4;
      CS_BRANCH: next_pc = taken ? (pc4 + branch_offset) : pc4;
      CS_JUMP:   next_pc = {pc4[31:28], jump_target, 2'b00};
      CS_JREG:   next_pc = {reg_target_hi, 2'b00};
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// KGP RISC fetch stage: PC register, request/valid imem handshake with
// re-issue on timeout, and instruction hold until the core retires it.
module instruction_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  function_val,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  input  logic        instr_done,
  input  logic [2:0]  branch_type,
  input  logic [1:0]  counter_selector,
  input  logic        flag_zero,
  input  logic        flag_carry,
  input  logic        flag_sign,
  input  logic        flag_overflow,
  input  logic [31:0] reg_target,
  output logic        fetch_timeout
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [7:0]   wait_cnt_q, wait_cnt_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  next_pc;
  logic         taken;
  logic         unused_ok;

  next_pc_logic u_next_pc_logic (
    .pc               (pc_q),
    .imm16            (instr_q[IMM_MSB:IMM_LSB]),
    .jump_target      (instr_q[JTARGET_MSB:JTARGET_LSB]),
    .counter_selector (counter_selector),
    .branch_type      (branch_type),
    .flag_zero        (flag_zero),
    .flag_carry       (flag_carry),
    .flag_sign        (flag_sign),
    .flag_overflow    (flag_overflow),
    .reg_target_hi    (reg_target[31:2]),
    .taken            (taken),
    .next_pc          (next_pc)
  );

  // Jump-register targets are word aligned, so the low target bits are dropped.
  assign unused_ok = ^{taken, reg_target[1:0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == MaxWait) begin
            timeout_d = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_ISSUE: begin
        if (instr_done) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // The request is held off while reset is asserted even though the state is FETCH.
  assign imem_req      = rst_n & (state_q == ST_FETCH);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign fetch_timeout = timeout_q;
  assign instr_valid   = (state_q == ST_ISSUE);
  assign instr         = instr_q;
  assign opcode        = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign function_val  = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign rs            = instr_q[RS_MSB:RS_LSB];
  assign rt            = instr_q[RT_MSB:RT_LSB];
  assign imm16         = instr_q[IMM_MSB:IMM_LSB];

endmodule
